// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions: datapath widths, queue depth and the queue entry type.
package fetch_queue_pkg;

    // Core datapath widths shared by fetch and decode.
    localparam int unsigned INSTR_LEN = 32;
    localparam int unsigned XLEN      = 32;

    // Depth of the instruction queue between fetch and decode.
    localparam int unsigned FETCH_QUEUE_DEPTH = 4;

    // One queued fetch result; decode reuses this type.
    typedef struct packed {
        logic [INSTR_LEN-1:0] instr;
        logic [XLEN-1:0]      tag;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode. It is a circular FIFO of {instr, tag} entries.
// pipe_stall is taken from registered occupancy only, so decode never reaches back into fetch
// combinationally. flush empties the queue in one cycle for redirects.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [INSTR_LEN-1:0] in_instr,
    input  logic                 in_valid,
    input  logic [XLEN-1:0]      in_tag,
    output logic                 pipe_stall,
    output logic [INSTR_LEN-1:0] out_instr,
    output logic [XLEN-1:0]      out_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     count
);

    // Pointers wrap modulo DEPTH; fullness comes from the counter, so no extra wrap bit.
    localparam int unsigned PTR_W = $clog2(DEPTH);

    fq_entry_t        mem_q [DEPTH];
    fq_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Status and handshake qualifiers; flush cancels both push and pop.
    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        push  = in_valid & ~full & ~flush;
        pop   = ~empty & out_ready & ~flush;
    end

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: in_instr, tag: in_tag};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // Push while full is already blocked above, so this never exceeds DEPTH.
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers; reset clears storage too so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Outputs: head entry is a direct read of registered storage (no bypass).
    always_comb begin
        out_instr  = mem_q[rd_ptr_q].instr;
        out_tag    = mem_q[rd_ptr_q].tag;
        out_valid  = ~empty;
        pipe_stall = full;
        count      = count_q;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue directly downstream of the fetch unit. It captures each registered fetch result (instruction, valid, PC tag) into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake. It produces the fetch unit's `pipe_stall` from its own registered occupancy, so there is no combinational path from decode back into fetch. A synchronous flush input discards all queued entries, reserved for redirects.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `CNT_W`, default `$clog2(DEPTH+1)`: occupancy counter width.

Ports:
- `clk`  in  1  core clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard all entries this cycle.
- `in_instr`  in  INSTR_LEN  instruction from fetch.
- `in_valid`  in  1  fetch output valid.
- `in_tag`  in  XLEN  PC tag of `in_instr`.
- `pipe_stall`  out  1  back-pressure to fetch; equals queue full.
- `out_instr`  out  INSTR_LEN  oldest entry's instruction.
- `out_tag`  out  XLEN  oldest entry's PC tag.
- `out_valid`  out  1  queue non-empty.
- `out_ready`  in  1  decode accepts the head entry this cycle.
- `count`  out  CNT_W  current occupancy, 0..DEPTH.

## Operation
- Storage: `DEPTH` entries of {instr, tag}. Write pointer and read pointer are each `$clog2(DEPTH)` bits and wrap naturally modulo `DEPTH`. Occupancy is kept in `count`.
- `full = (count == DEPTH)`, `empty = (count == 0)`. Both come from registered state only.
- push = `in_valid & ~full & ~flush`. Writes entry[wr_ptr] and increments wr_ptr.
- pop = `out_valid & out_ready & ~flush`. Increments rd_ptr.
- `count` next value is `count + push - pop`. Simultaneous push and pop leaves it unchanged.
- Full: push is blocked even if pop happens the same cycle. The fetch unit holds its output while stalled, so the instruction is re-presented and accepted next cycle. No data is lost and none is duplicated.
- Empty: `out_valid` = 0. There is no bypass; a pushed entry appears the following cycle.
- Flush has priority over everything. Next cycle: wr_ptr = rd_ptr = 0, count = 0. The push and pop of the flush cycle are both cancelled.
- `pipe_stall` = `full`.
- `out_instr` / `out_tag` = entry[rd_ptr] (combinational read of registered storage). Their value is don't-care when `out_valid` = 0.
- Width rules: `count` has CNT_W bits, so DEPTH is representable. Pointers have no extra wrap bit, because fullness comes from `count`.

## Timing
- Reset (async assert, sync-safe deassert): pointers = 0, count = 0, storage = 0. So `out_valid` = 0, `pipe_stall` = 0, `out_instr` = 0, `out_tag` = 0, `count` = 0.
- Latency: input at edge N → visible at output after edge N (cycle N+1) when the queue was empty.
- Throughput: 1 push and 1 pop per cycle sustained when neither full nor empty.
- Stall propagation: reaching full at edge N asserts `pipe_stall` in cycle N+1. The fetch unit's enable drops the same cycle, which keeps its registered output stable.
- Reset asserted mid-operation clears all state immediately. Queued entries are lost.

## Structure
- `INSTR_LEN`, `XLEN` come from `global.svh`.
- Add `FETCH_QUEUE_DEPTH` (= 4) to the shared global package. The top level passes it as `DEPTH`.
- An entry typedef `fq_entry_t` {instr, tag} goes in the same package for reuse by decode.
- No sub-module. A single always_ff for pointers/count and storage, plus combinational outputs, is under 200 lines.
- Top-level wiring: fetch `instr/instr_valid/instr_tag` → `in_*`; `pipe_stall` → fetch `pipe_stall`.

## Test plan
- Reset with `in_valid` = 1 held → all outputs 0 during reset; after release, first tag 0x0 appears at `out_tag` one cycle after its push.
- `out_ready` = 0, push tags 0x0, 0x4, 0x8, 0xC → `count` = 4 and `pipe_stall` = 1. A fifth tag 0x10 held on input is not written. Then raise `out_ready` → pops come out in order 0x0, 0x4, 0x8, 0xC, 0x10, with no duplicate and no loss.
- Full, with `out_ready` = 1 and `in_valid` = 1 in the same cycle → count goes 4→3, and 0x10 is pushed the next cycle (count 3→4).
- Streaming 12 sequential tags with `out_ready` = 1 every cycle → `count` stays 1, pointers wrap 3→0 three times, and output order is intact.
- `flush` asserted with count = 3 and concurrent push/pop → next cycle `count` = 0 and `out_valid` = 0. The next push of tag 0x40 is the first output.
- Async reset asserted mid-stream with count = 2 → outputs clear without waiting for a clock edge.
